pwm_transmitter: RTL

- Generates the PWM waveform consumed by the team's PWM position receiver: one fixed-length frame per period.
- The high time equals the commanded 10-bit position in ticks; 1 tick = PRESCALE clocks.
- A shadow register with a write strobe accepts new positions at any time. Updates apply only at period boundaries, so no frame is ever truncated or glitched.
- Sits between the position command logic and the pwm pin / loopback into the receiver.

---
 rtl/pwm_transmitter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_transmitter.sv
// -----------------------------------------------------------------------------
// pwm_transmitter
//
// Produces the fixed-length PWM frame consumed by the PWM position receiver.
// Each frame lasts PERIOD ticks. The output is high for the first
// active_position ticks and low for the rest of the frame. One tick is
// PRESCALE clock cycles.
//
// A new position is written into a shadow register at any time. The shadow
// value is copied into the active duty only when a frame starts. A frame
// that is already running is therefore never shortened or glitched.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high; overrides every other input
//   enable          in   level; 1 = transmit frames, 0 = idle with pwm low
//   wr_en           in   one-cycle strobe; loads wr_position into the shadow
//   wr_position     in   [WIDTH-1:0] commanded position in ticks
//   pwm             out  registered PWM waveform
//   period_start    out  one-cycle pulse on the clock where a frame begins
//   active_position out  [WIDTH-1:0] duty of the frame now being sent
//   update_pending  out  the shadow holds a value no frame has taken yet
//
// Parameters
//   WIDTH     position width; the largest duty is 2^WIDTH-1 ticks
//   PERIOD    frame length in ticks; must be >= 2^WIDTH+1 so the receiver
//             always sees a low time long enough for its zero detection
//   PRESCALE  clock cycles per tick; must be >= 1
// -----------------------------------------------------------------------------
module pwm_transmitter #(
    parameter int WIDTH    = 10,
    parameter int PERIOD   = 2048,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_position,
    output logic             pwm,
    output logic             period_start,
    output logic [WIDTH-1:0] active_position,
    output logic             update_pending
);

    // The tick counter only needs to reach PERIOD-1. Because PERIOD exceeds
    // 2^WIDTH, CNT_W is always wider than WIDTH, so a zero-extended duty fits.
    localparam int CNT_W = $clog2(PERIOD);
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shadow_r;
    logic [PS_W-1:0]  ps_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pwm_r;
    logic             period_start_r;
    logic [WIDTH-1:0] active_r;
    logic             pending_r;

    logic             tick_s;
    logic             high_last_s;
    logic             frame_last_s;
    logic             start_s;
    logic [CNT_W-1:0] high_last_cnt_s;

    // Tick generation and frame boundary decode.
    always_comb begin
        tick_s          = 1'b0;
        high_last_s     = 1'b0;
        frame_last_s    = 1'b0;
        start_s         = 1'b0;
        high_last_cnt_s = CNT_W'(active_r) - CNT_W'(1);

        if (state_r != ST_IDLE) begin
            tick_s = (ps_r == PS_LAST);
        end else begin
            tick_s = 1'b0;
        end

        // The HIGH state is entered only with a non-zero duty, so
        // active_r-1 cannot wrap while this compare is in use.
        high_last_s  = tick_s && (state_r == ST_HIGH) && (cnt_r == high_last_cnt_s);
        frame_last_s = tick_s && (state_r == ST_LOW) && (cnt_r == CNT_LAST);

        // A frame starts either from idle or back-to-back on the last tick.
        if (enable) begin
            start_s = (state_r == ST_IDLE) || frame_last_s;
        end else begin
            start_s = 1'b0;
        end
    end

    // Shadow register and pending flag. A write on the frame-start clock wins,
    // because that frame already takes the old shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r  <= {WIDTH{1'b0}};
            pending_r <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_r  <= wr_position;
                pending_r <= 1'b1;
            end else if (start_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Frame state machine with prescaler, tick counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            ps_r           <= {PS_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            pwm_r          <= 1'b0;
            period_start_r <= 1'b0;
            active_r       <= {WIDTH{1'b0}};
        end else begin
            period_start_r <= 1'b0;
            if (start_s) begin
                active_r       <= shadow_r;
                cnt_r          <= {CNT_W{1'b0}};
                ps_r           <= {PS_W{1'b0}};
                period_start_r <= 1'b1;
                if (shadow_r != {WIDTH{1'b0}}) begin
                    state_r <= ST_HIGH;
                    pwm_r   <= 1'b1;
                end else begin
                    state_r <= ST_LOW;
                    pwm_r   <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        pwm_r <= 1'b0;
                        ps_r  <= {PS_W{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                    end
                    ST_HIGH: begin
                        if (tick_s) begin
                            ps_r  <= {PS_W{1'b0}};
                            cnt_r <= cnt_r + CNT_W'(1);
                            if (high_last_s) begin
                                state_r <= ST_LOW;
                                pwm_r   <= 1'b0;
                            end else begin
                                pwm_r   <= 1'b1;
                            end
                        end else begin
                            ps_r <= ps_r + PS_W'(1);
                        end
                    end
                    ST_LOW: begin
                        pwm_r <= 1'b0;
                        if (tick_s) begin
                            ps_r <= {PS_W{1'b0}};
                            if (frame_last_s) begin
                                // Only reached with enable low; otherwise
                                // start_s took the back-to-back branch.
                                state_r <= ST_IDLE;
                                cnt_r   <= {CNT_W{1'b0}};
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end else begin
                            ps_r <= ps_r + PS_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        pwm_r   <= 1'b0;
                        ps_r    <= {PS_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign pwm             = pwm_r;
    assign period_start    = period_start_r;
    assign active_position = active_r;
    assign update_pending  = pending_r;

endmodule
